n64_eeprom_bridge_core: RTL and testbench

//  Parametrised CPU-to-serial-EEPROM bridge: byte register bus, synchronous TX/RX FIFOs of configurable depth,

---
 rtl/n64_eeprom_bridge_core.sv | 271 +++++++++++++++++++++++++++
 tb/tb_n64_eeprom_bridge_core.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_eeprom_bridge_core.sv
// n64_eeprom_bridge_core: CPU byte-register bus bridged to a byte-level serial
// EEPROM engine. Holds TX/RX FIFOs, a transaction sequencer with parameter
// checks, a watchdog, a free-running engine tick and a level interrupt.

// Synchronous byte FIFO, first-word-fall-through head.
module n64_eeprom_fifo #(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_head,
  output logic          o_empty,
  output logic          o_drop,
  output logic [LW-1:0] o_lvl
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_lvl;
  logic          w_full, w_pop_ok, w_push_ok;

  assign o_empty   = (r_lvl == '0);
  assign w_full    = (r_lvl == LW'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = i_push & (~w_full | w_pop_ok);
  assign o_drop    = i_push & ~w_push_ok;
  assign o_head    = r_mem[r_rp];
  assign o_lvl     = r_lvl;

  // Pointer and level bookkeeping; flush empties without touching storage.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop_ok)  r_rp <= r_rp + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage write; contents are don't-care while the entry is not valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= i_din;
  end
endmodule

module n64_eeprom_bridge_core #(
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_W      = 15,
  parameter int CLK_DIV     = 500,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic [3:0]        address,
  input  logic [7:0]        data_in_bus,
  input  logic              write,
  input  logic              ce,
  output logic              valid,
  output logic [7:0]        data_out_bus,
  output logic              irq,
  output logic              eng_tick,
  output logic              eng_start,
  output logic              eng_rw,
  output logic [7:0]        eng_nbytes,
  output logic [ADDR_W-1:0] eng_addr,
  output logic              eng_abort,
  input  logic              eng_done,
  input  logic              eng_nack,
  input  logic              eng_tx_req,
  output logic [7:0]        eng_tx_data,
  input  logic              eng_rx_valid,
  input  logic [7:0]        eng_rx_data
);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PSW = $clog2(CLK_DIV);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN} state_t;

  state_t         r_state;
  logic           r_rw, r_irq_en;
  logic [7:0]     r_addr_hi, r_addr_lo, r_count;
  logic           r_done, r_err_nack, r_err_to, r_err_param, r_err_ovf;
  logic [PSW-1:0] r_pre;
  logic [WDW-1:0] r_wd;

  logic           w_rd, w_wr, w_busy, w_run, w_ctrl_wr, w_start, w_clr;
  logic           w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_flush_tx, w_flush_rx;
  logic [7:0]     w_tx_head, w_rx_head, w_rdata, w_status;
  logic           w_tx_empty, w_rx_empty, w_tx_drop, w_rx_drop, w_ovf_evt, w_param_bad;
  logic [LW-1:0]  w_tx_lvl, w_rx_lvl;
  logic [15:0]    w_addr16;

  assign w_rd       = ce & ~write;
  assign w_wr       = ce & write;
  assign w_busy     = (r_state != S_IDLE);
  assign w_run      = (r_state == S_RUN);
  assign w_ctrl_wr  = w_wr & (address == 4'd5);
  assign w_start    = w_ctrl_wr & data_in_bus[0] & ~w_busy;
  assign w_clr      = w_ctrl_wr & data_in_bus[4];
  assign w_flush_rx = w_ctrl_wr & data_in_bus[1] & ~w_busy;
  assign w_flush_tx = w_ctrl_wr & data_in_bus[2] & ~w_busy;
  assign w_tx_push  = w_wr & (address == 4'd7);
  assign w_tx_pop   = w_run & eng_tx_req;
  assign w_rx_push  = w_run & eng_rx_valid;
  assign w_rx_pop   = w_rd & (address == 4'd6);
  assign w_addr16   = {r_addr_hi, r_addr_lo};

  n64_eeprom_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_tx (
    .clk(clk), .reset_l(reset_l), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_flush(w_flush_tx),
    .i_din(data_in_bus), .o_head(w_tx_head), .o_empty(w_tx_empty), .o_drop(w_tx_drop), .o_lvl(w_tx_lvl));

  n64_eeprom_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_rx (
    .clk(clk), .reset_l(reset_l), .i_push(w_rx_push), .i_pop(w_rx_pop), .i_flush(w_flush_rx),
    .i_din(eng_rx_data), .o_head(w_rx_head), .o_empty(w_rx_empty), .o_drop(w_rx_drop), .o_lvl(w_rx_lvl));

  // Engine underrun is reported as an overflow error and filled with 8'hFF.
  assign w_ovf_evt   = w_tx_drop | w_rx_drop | (w_tx_pop & w_tx_empty);
  assign eng_tx_data = w_tx_empty ? (w_run ? 8'hFF : 8'h00) : w_tx_head;
  assign w_status    = {w_busy, r_done, r_err_nack, r_err_to, r_err_param, r_err_ovf,
                        w_rx_empty, w_tx_empty};
  assign w_param_bad = (r_count == 8'd0) | ({1'b0, r_count} > 9'(FIFO_DEPTH)) |
                       (~r_rw & (9'(w_tx_lvl) < {1'b0, r_count}));
  assign eng_tick    = (r_pre == PSW'(CLK_DIV - 1));

  // Register read mux.
  always_comb begin
    w_rdata = 8'h00;
    case (address)
      4'd0: w_rdata = {7'b0, r_rw};
      4'd1: w_rdata = r_addr_hi;
      4'd2: w_rdata = r_addr_lo;
      4'd3: w_rdata = r_count;
      4'd4: w_rdata = w_status;
      4'd5: w_rdata = {4'b0, r_irq_en, 3'b0};
      4'd6: w_rdata = w_rx_empty ? 8'h00 : w_rx_head;
      4'd8: w_rdata = 8'(w_rx_lvl);
      4'd9: w_rdata = 8'(w_tx_lvl);
      default: ;
    endcase
  end

  // Bus acknowledge, registered read data and configuration registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      valid        <= 1'b0;
      data_out_bus <= 8'h00;
      r_rw         <= 1'b0;
      r_addr_hi    <= 8'h00;
      r_addr_lo    <= 8'h00;
      r_count      <= 8'h00;
      r_irq_en     <= 1'b0;
    end else begin
      valid        <= ce;
      data_out_bus <= w_rd ? w_rdata : 8'h00;
      if (w_wr & ~w_busy) begin
        case (address)
          4'd0:    r_rw      <= data_in_bus[0];
          4'd1:    r_addr_hi <= data_in_bus;
          4'd2:    r_addr_lo <= data_in_bus;
          4'd3:    r_count   <= data_in_bus;
          default: ;
        endcase
      end
      if (w_ctrl_wr) r_irq_en <= data_in_bus[3];
    end
  end

  // Transaction sequencer, sticky flags, watchdog and engine command outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_err_nack  <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_param <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_wd        <= '0;
      eng_start   <= 1'b0;
      eng_abort   <= 1'b0;
      eng_rw      <= 1'b0;
      eng_nbytes  <= 8'h00;
      eng_addr    <= '0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      // Clears come first so any event in the same cycle still lands.
      if (w_clr) begin
        r_done      <= 1'b0;
        r_err_nack  <= 1'b0;
        r_err_to    <= 1'b0;
        r_err_param <= 1'b0;
        r_err_ovf   <= 1'b0;
      end
      if (w_ovf_evt) r_err_ovf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_done      <= 1'b0;
            r_err_nack  <= 1'b0;
            r_err_to    <= 1'b0;
            r_err_param <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_param_bad) begin
            r_err_param <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            eng_rw     <= r_rw;
            eng_nbytes <= r_count;
            eng_addr   <= w_addr16[ADDR_W-1:0];
            eng_start  <= 1'b1;
            r_wd       <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          // Completion on the timeout cycle beats the watchdog.
          if (eng_done) begin
            r_done     <= 1'b1;
            r_err_nack <= eng_nack;
            r_state    <= S_IDLE;
          end else if (r_wd == WDW'(TIMEOUT_CYC - 1)) begin
            eng_abort <= 1'b1;
            r_err_to  <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered interrupt level from the sticky flags.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) irq <= 1'b0;
    else          irq <= (r_done | r_err_nack | r_err_to | r_err_param | r_err_ovf) & r_irq_en;
  end

  // Free-running engine tick prescaler.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)                          r_pre <= '0;
    else if (r_pre == PSW'(CLK_DIV - 1))   r_pre <= '0;
    else                                   r_pre <= r_pre + 1'b1;
  end
endmodule

// File: tb/tb_n64_eeprom_bridge_core.sv
// Randomized bench for n64_eeprom_bridge_core with a queue-based reference model.
module tb_n64_eeprom_bridge_core;
  localparam int D  = 8;
  localparam int AW = 15;
  localparam int CD = 5;
  localparam int TO = 60;

  logic          clk = 1'b0, reset_l = 1'b0;
  logic [3:0]    address = '0;
  logic [7:0]    data_in_bus = '0;
  logic          write = 1'b0, ce = 1'b0;
  logic          valid, irq, eng_tick, eng_start, eng_rw, eng_abort;
  logic [7:0]    data_out_bus, eng_nbytes, eng_tx_data;
  logic [AW-1:0] eng_addr;
  logic          eng_done = 1'b0, eng_nack = 1'b0, eng_tx_req = 1'b0, eng_rx_valid = 1'b0;
  logic [7:0]    eng_rx_data = '0;

  n64_eeprom_bridge_core #(.FIFO_DEPTH(D), .ADDR_W(AW), .CLK_DIV(CD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_l(reset_l), .address(address), .data_in_bus(data_in_bus), .write(write),
    .ce(ce), .valid(valid), .data_out_bus(data_out_bus), .irq(irq), .eng_tick(eng_tick),
    .eng_start(eng_start), .eng_rw(eng_rw), .eng_nbytes(eng_nbytes), .eng_addr(eng_addr),
    .eng_abort(eng_abort), .eng_done(eng_done), .eng_nack(eng_nack), .eng_tx_req(eng_tx_req),
    .eng_tx_data(eng_tx_data), .eng_rx_valid(eng_rx_valid), .eng_rx_data(eng_rx_data));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int n_start = 0, n_abort = 0, cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (eng_start) n_start++;
    if (eng_abort) n_abort++;
  end

  // reference model
  logic [7:0] m_tx[$], m_rx[$], rx_src[$];
  bit m_done, m_nack, m_to, m_param, m_ovf, m_irq_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    m_done = 0; m_nack = 0; m_to = 0; m_param = 0; m_ovf = 0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); ce = 1; write = 1; address = a; data_in_bus = d;
    @(negedge clk); ce = 0; write = 0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); ce = 1; write = 0; address = a;
    @(negedge clk); d = data_out_bus; ce = 0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    bus_wr(4'd7, b);
    if (m_tx.size() < D) m_tx.push_back(b); else m_ovf = 1;
  endtask

  task automatic pop_rx_chk(input string tag);
    logic [7:0] d, e;
    bus_rd(4'd6, d);
    e = (m_rx.size() != 0) ? m_rx.pop_front() : 8'h00;
    chk(tag, d, e);
  endtask

  task automatic ctrl(input logic [7:0] d);
    bus_wr(4'd5, d);
    m_irq_en = d[3];
    if (d[4]) m_clear();
    if (d[1]) m_rx.delete();
    if (d[2]) m_tx.delete();
  endtask

  task automatic chk_state(input string tag);
    logic [7:0] d;
    bus_rd(4'd4, d);
    chk({tag, "_status"}, d, {1'b0, m_done, m_nack, m_to, m_param, m_ovf,
                              m_rx.size() == 0, m_tx.size() == 0});
    bus_rd(4'd8, d); chk({tag, "_rxlvl"}, d, m_rx.size());
    bus_rd(4'd9, d); chk({tag, "_txlvl"}, d, m_tx.size());
    chk({tag, "_irq"}, irq, (m_done | m_nack | m_to | m_param | m_ovf) & m_irq_en);
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (eng_start) begin ok = 1; break; end
    end
  endtask

  task automatic setup(input bit rw, input logic [7:0] cnt, output logic [15:0] a16);
    a16 = 16'($urandom);
    bus_wr(4'd0, {7'b0, rw});
    bus_wr(4'd1, a16[15:8]);
    bus_wr(4'd2, a16[7:0]);
    bus_wr(4'd3, cnt);
  endtask

  task automatic txn(input string tag, input bit rw, input logic [7:0] cnt, input bit nack,
                     input int extra);
    logic [15:0] a16;
    logic [7:0]  e, b;
    int s0;
    bit ok;
    setup(rw, cnt, a16);
    s0 = n_start;
    bus_wr(4'd5, {4'b0, m_irq_en, 3'b001});
    m_clear();
    if (cnt == 0 || cnt > D || (!rw && m_tx.size() < cnt)) begin
      m_param = 1; m_done = 1;
      repeat (4) @(negedge clk);
      chk({tag, "_nostart"}, n_start - s0, 0);
    end else begin
      wait_start(ok);
      chk({tag, "_start"}, ok, 1);
      chk({tag, "_rw"}, eng_rw, rw);
      chk({tag, "_nbytes"}, eng_nbytes, cnt);
      chk({tag, "_addr"}, eng_addr, a16[AW-1:0]);
      if (!rw) begin
        for (int i = 0; i < int'(cnt) + extra; i++) begin
          if (m_tx.size() != 0) e = m_tx.pop_front();
          else begin e = 8'hFF; m_ovf = 1; end
          chk({tag, "_txd"}, eng_tx_data, e);
          eng_tx_req = 1;
          @(negedge clk); eng_tx_req = 0;
          if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
      end else begin
        for (int i = 0; i < int'(cnt); i++) begin
          b = (rx_src.size() != 0) ? rx_src.pop_front() : 8'($urandom);
          if (m_rx.size() < D) m_rx.push_back(b); else m_ovf = 1;
          eng_rx_valid = 1; eng_rx_data = b;
          @(negedge clk); eng_rx_valid = 0;
          if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
      end
      eng_done = 1; eng_nack = nack;
      @(negedge clk); eng_done = 0; eng_nack = 0;
      m_done = 1; m_nack = nack;
      chk({tag, "_once"}, n_start - s0, 1);
    end
    chk_state(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0]  d;
    logic [15:0] a16;
    int c0, s0, a0, t0;
    bit ok;

    // reset state
    m_clear(); m_irq_en = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {valid, data_out_bus, irq, eng_tick, eng_start, eng_rw, eng_abort}, 0);
    chk("rst_eng", {eng_addr, eng_nbytes, eng_tx_data}, 0);
    reset_l = 1;
    @(negedge clk);
    bus_rd(4'd4, d); chk("rst_status", d, 8'h03);
    chk_state("rst");

    // register readback, unmapped read, valid strobe
    bus_wr(4'd1, 8'h5A); bus_wr(4'd2, 8'hC3);
    bus_rd(4'd1, d); chk("rb_hi", d, 8'h5A);
    @(negedge clk); ce = 1; address = 4'd2;
    @(negedge clk); chk("rb_lo", data_out_bus, 8'hC3); chk("valid", valid, 1); ce = 0;
    @(negedge clk); chk("valid_off", valid, 0); chk("dout_idle", data_out_bus, 0);
    bus_rd(4'd12, d); chk("unmapped", d, 0);

    // tick period
    ok = 0;
    for (int k = 0; k < 4 * CD; k++) begin @(negedge clk); if (eng_tick) begin ok = 1; break; end end
    chk("tick_seen", ok, 1);
    t0 = cyc;
    @(negedge clk); chk("tick_width", eng_tick, 0);
    for (int k = 0; k < 4 * CD; k++) begin if (eng_tick) break; @(negedge clk); end
    chk("tick_period", cyc - t0, CD);

    // directed write and read
    push_tx(8'hAA); push_tx(8'hBB); push_tx(8'hCC); push_tx(8'hDD);
    txn("wr4", 0, 8'd4, 0, 0);
    rx_src = '{8'h11, 8'h22, 8'h33};
    txn("rd3", 1, 8'd3, 0, 0);
    pop_rx_chk("rx0"); pop_rx_chk("rx1"); pop_rx_chk("rx2"); pop_rx_chk("rx_empty");

    // parameter errors with interrupt enabled
    ctrl(8'h08);
    txn("cnt0", 1, 8'd0, 0, 0);
    txn("cntbig", 1, 8'(D + 1), 0, 0);
    bus_rd(4'd5, d); chk("irq_en_rd", d, 8'h08);
    txn("cntmax", 1, 8'(D), 0, 0);
    ctrl(8'h1A);
    chk_state("clr");

    // TX overflow then flush
    for (int i = 0; i < D + 1; i++) push_tx(8'(i + 1));
    chk_state("ovf");
    ctrl(8'h04);
    chk_state("flush");

    // watchdog timeout; config writes ignored while running
    setup(1, 8'd2, a16);
    a0 = n_abort;
    bus_wr(4'd5, 8'h01); m_clear();
    wait_start(ok); chk("to_start", ok, 1);
    c0 = cyc;
    bus_wr(4'd3, 8'h77);
    s0 = n_start;
    bus_wr(4'd5, 8'h01);
    ok = 0;
    for (int k = 0; k < TO + 20; k++) begin @(negedge clk); if (eng_abort) begin ok = 1; break; end end
    chk("to_abort", ok, 1);
    chk("to_cycles", cyc - c0, TO);
    chk("to_busy_start", n_start - s0, 0);
    @(negedge clk); chk("to_pulse", n_abort - a0, 1);
    m_to = 1; m_done = 1;
    bus_rd(4'd3, d); chk("to_cnt_kept", d, 8'd2);
    chk_state("to");

    // completion on the watchdog cycle wins
    setup(1, 8'd0 + 8'd1, a16);
    a0 = n_abort;
    bus_wr(4'd5, 8'h00 | 8'h01); m_clear(); m_irq_en = 0;
    wait_start(ok); chk("dw_start", ok, 1);
    c0 = cyc;
    while (cyc - c0 < TO - 1) @(negedge clk);
    eng_done = 1;
    @(negedge clk); eng_done = 0;
    repeat (3) @(negedge clk);
    chk("dw_noabort", n_abort - a0, 0);
    m_done = 1;
    chk_state("dw");

    // randomized operation mix
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: for (int i = 0; i < int'($urandom_range(1, 4)); i++) push_tx(8'($urandom));
        1: txn("rw", 0, 8'($urandom_range(0, D + 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)));
        2: txn("rr", 1, 8'($urandom_range(0, D + 1)), 1'($urandom_range(0, 1)), 0);
        3: for (int i = 0; i < int'($urandom_range(1, 5)); i++) pop_rx_chk("rpop");
        default: ctrl({3'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0});
      endcase
      chk_state("rnd");
    end

    // reset during a running transaction
    setup(1, 8'd3, a16);
    bus_wr(4'd5, 8'h09);
    wait_start(ok); chk("rr_start", ok, 1);
    @(negedge clk); reset_l = 0;
    #1;
    chk("rr_ctl", {valid, data_out_bus, irq, eng_tick, eng_start, eng_rw, eng_abort}, 0);
    chk("rr_eng", {eng_addr, eng_nbytes, eng_tx_data}, 0);
    @(negedge clk); reset_l = 1;
    m_clear(); m_irq_en = 0; m_tx.delete(); m_rx.delete();
    bus_rd(4'd4, d); chk("rr_status", d, 8'h03);
    chk_state("rr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
